// File: rtl/alu_driver.sv
// alu_driver: registers one request at a time into an external combinational
// ALU, captures its result one cycle later and buffers results in a small FIFO
// that a downstream consumer drains with a valid/ready handshake.
// Optional feature macro: ALU_DRIVER_STICKY_OF_EN adds a sticky overflow output.
module alu_driver #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [2:0]  alu_op,
    output logic [31:0] a,
    output logic [31:0] b,
    input  logic [31:0] f,
    input  logic        zf,
    input  logic        of,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_f,
    output logic        rsp_zf,
    output logic        rsp_of
`ifdef ALU_DRIVER_STICKY_OF_EN
    ,
    output logic        sticky_of
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           push;
    logic           pop;
    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [33:0]    mem [DEPTH];
    logic [33:0]    head;

    // FSM state register; reset abandons any operation that was in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake decode: accept only when idle and the FIFO has
    // room, so the result captured in BUSY always has a slot to land in
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = (count < FULL);
                accept    = req_valid && (count < FULL);
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                push       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand/opcode registers feeding the ALU; they only change on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op <= 3'b000;
            a      <= 32'd0;
            b      <= 32'd0;
        end else if (accept) begin
            alu_op <= req_op;
            a      <= req_a;
            b      <= req_b;
        end
    end

    // Result storage; contents need no reset because the output is masked
    // whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {f, zf, of};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Response side: head of FIFO presented while non-empty, zeros otherwise
    always_comb begin
        rsp_valid = (count != '0);
        pop       = rsp_valid && rsp_ready;
        head      = mem[rd_ptr];
        rsp_f     = 32'd0;
        rsp_zf    = 1'b0;
        rsp_of    = 1'b0;
        if (rsp_valid) begin
            rsp_f  = head[33:2];
            rsp_zf = head[1];
            rsp_of = head[0];
        end
    end

`ifdef ALU_DRIVER_STICKY_OF_EN
    // Remembers that some overflowing result entered the FIFO since reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_of <= 1'b0;
        end else if (push && of) begin
            sticky_of <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: drives alu_driver with a behavioural ALU attached and compares
// its outputs against a transaction-level queue model kept in the bench.
module tb_alu_driver;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
    logic        zf;
    logic        of;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_f;
    logic        rsp_zf;
    logic        rsp_of;
`ifdef ALU_DRIVER_STICKY_OF_EN
    logic        sticky_of;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [33:0] m_q[$];
    logic [33:0] m_pending;
    bit          m_busy;
    bit          m_sticky;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;

    alu_driver #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .f         (f),
        .zf        (zf),
        .of        (of),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_zf    (rsp_zf),
        .rsp_of    (rsp_of)
`ifdef ALU_DRIVER_STICKY_OF_EN
        ,
        .sticky_of (sticky_of)
`endif
    );

    // Behavioural ALU: returns {result, zero flag, signed overflow flag}
    function automatic logic [33:0] alu_calc(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        case (op)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x | y);
            3'd4: begin r = x + y; ov = (x[31] == y[31]) && (r[31] != x[31]); end
            3'd5: begin r = x - y; ov = (x[31] != y[31]) && (r[31] != x[31]); end
            3'd6: r = {31'd0, $signed(x) < $signed(y)};
            default: r = x << y[4:0];
        endcase
        return {r, (r == 32'd0), ov};
    endfunction

    assign {f, zf, of} = alu_calc(alu_op, a, b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog in case the run stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit model_ready();
        return !m_busy && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy    = 1'b0;
        m_sticky  = 1'b0;
        m_pending = '0;
        m_op      = 3'd0;
        m_a       = 32'd0;
        m_b       = 32'd0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model across the next edge,
    // and return at the following falling edge
    task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic [31:0] x,
                                  input logic [31:0] y, input logic rr);
        bit acc;
        bit do_pop;
        bit do_push;
        req_valid = v;
        req_op    = op;
        req_a     = x;
        req_b     = y;
        rsp_ready = rr;
        acc     = v && model_ready();
        do_pop  = rr && (m_q.size() != 0);
        do_push = m_busy;
        if (do_pop) m_q.delete(0);
        if (do_push) begin
            m_q.push_back(m_pending);
            if (m_pending[0]) m_sticky = 1'b1;
        end
        m_busy = acc;
        if (acc) begin
            m_op      = op;
            m_a       = x;
            m_b       = y;
            m_pending = alu_calc(op, x, y);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b1; req_op = 3'd4; req_a = 32'd9; req_b = 32'd9; rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        checks++; if (alu_op !== 3'd0) begin errors++; $display("[TB] FAIL reset_alu_op: got %0d expected 0", alu_op); end
        checks++; if (a !== 32'd0 || b !== 32'd0) begin errors++; $display("[TB] FAIL reset_ab: got %h/%h expected 0/0", a, b); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if ({rsp_f, rsp_zf, rsp_of} !== 34'd0) begin errors++; $display("[TB] FAIL reset_rsp: got %h %b %b expected 0", rsp_f, rsp_zf, rsp_of); end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
`ifdef ALU_DRIVER_STICKY_OF_EN
        checks++; if (sticky_of !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky: got %b expected 0", sticky_of); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_cycle_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_add();
        apply_stimulus(1'b1, 3'b100, 32'd7, 32'd5, 1'b1);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL add_busy_ready: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_early_valid: got %b expected 0", rsp_valid); end
        checks++; if ({alu_op, a, b} !== {3'b100, 32'd7, 32'd5}) begin errors++; $display("[TB] FAIL add_latched: got %0d %h %h expected 4 7 5", alu_op, a, b); end
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_latency: got %b expected 1", rsp_valid); end
        checks++; if ({rsp_f, rsp_zf, rsp_of} !== {32'h0000_000C, 2'b00}) begin errors++; $display("[TB] FAIL add_result: got %h %b %b expected 0000000c 0 0", rsp_f, rsp_zf, rsp_of); end
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_popped: got %b expected 0", rsp_valid); end
        checks++; if ({alu_op, a, b} !== {3'b100, 32'd7, 32'd5}) begin errors++; $display("[TB] FAIL add_hold: got %0d %h %h expected 4 7 5", alu_op, a, b); end
    endtask

    task automatic test_sub();
        apply_stimulus(1'b1, 3'b101, 32'd5, 32'd5, 1'b1);
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if ({rsp_valid, rsp_f, rsp_zf, rsp_of} !== {1'b1, 32'd0, 2'b10}) begin errors++; $display("[TB] FAIL sub_zero: got %b %h %b %b expected 1 0 1 0", rsp_valid, rsp_f, rsp_zf, rsp_of); end
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic test_overflow();
        apply_stimulus(1'b1, 3'b100, 32'h7FFF_FFFF, 32'd1, 1'b1);
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if ({rsp_valid, rsp_f, rsp_of} !== {1'b1, 32'h8000_0000, 1'b1}) begin errors++; $display("[TB] FAIL ovf_result: got %b %h %b expected 1 80000000 1", rsp_valid, rsp_f, rsp_of); end
`ifdef ALU_DRIVER_STICKY_OF_EN
        checks++; if (sticky_of !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_set: got %b expected 1", sticky_of); end
`endif
        apply_stimulus(1'b1, 3'b100, 32'd7, 32'd5, 1'b1);
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if ({rsp_f, rsp_of} !== {32'd12, 1'b0}) begin errors++; $display("[TB] FAIL ovf_followup: got %h %b expected 0000000c 0", rsp_f, rsp_of); end
`ifdef ALU_DRIVER_STICKY_OF_EN
        checks++; if (sticky_of !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_hold: got %b expected 1", sticky_of); end
`endif
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        apply_stimulus(1'b1, 3'b000, 32'hF0, 32'h3C, 1'b0);
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_one: got %b expected 1", req_ready); end
        apply_stimulus(1'b1, 3'b001, 32'hF0, 32'h0F, 1'b0);
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready: got %b expected 0", req_ready); end
        checks++; if ({rsp_valid, rsp_f} !== {1'b1, 32'h30}) begin errors++; $display("[TB] FAIL bp_head_first: got %b %h expected 1 00000030", rsp_valid, rsp_f); end
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        checks++; if ({req_ready, rsp_f} !== {1'b0, 32'h30}) begin errors++; $display("[TB] FAIL bp_stable: got %b %h expected 0 00000030", req_ready, rsp_f); end
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
        checks++; if ({rsp_valid, rsp_f} !== {1'b1, 32'hFF}) begin errors++; $display("[TB] FAIL bp_head_second: got %b %h expected 1 000000ff", rsp_valid, rsp_f); end
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [33:0] head;
        for (int i = 0; i < 12; i++) begin
            checks++; if (req_ready !== ((i % 2) == 0)) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", i, req_ready, ((i % 2) == 0)); end
            if (m_q.size() != 0) begin
                head = m_q[0];
                checks++; if ({rsp_valid, rsp_f, rsp_zf, rsp_of} !== {1'b1, head}) begin errors++; $display("[TB] FAIL b2b_rsp[%0d]: got %b %h %b %b expected 1 %h %b %b", i, rsp_valid, rsp_f, rsp_zf, rsp_of, head[33:2], head[1], head[0]); end
            end
            apply_stimulus(1'b1, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'b1);
        end
        repeat (2) apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [33:0] head;
        for (int i = 0; i < 400; i++) begin
            checks++; if (req_ready !== model_ready()) begin errors++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", i, req_ready, model_ready()); end
            checks++; if (rsp_valid !== (m_q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, rsp_valid, (m_q.size() != 0)); end
            if (m_q.size() != 0) begin
                head = m_q[0];
                checks++; if ({rsp_f, rsp_zf, rsp_of} !== head) begin errors++; $display("[TB] FAIL rnd_rsp[%0d]: got %h %b %b expected %h %b %b", i, rsp_f, rsp_zf, rsp_of, head[33:2], head[1], head[0]); end
            end
            checks++; if ({alu_op, a, b} !== {m_op, m_a, m_b}) begin errors++; $display("[TB] FAIL rnd_operands[%0d]: got %0d %h %h expected %0d %h %h", i, alu_op, a, b, m_op, m_a, m_b); end
`ifdef ALU_DRIVER_STICKY_OF_EN
            checks++; if (sticky_of !== m_sticky) begin errors++; $display("[TB] FAIL rnd_sticky[%0d]: got %b expected %b", i, sticky_of, m_sticky); end
`endif
            apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                           ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_reset_mid_op();
        apply_stimulus(1'b1, 3'b100, 32'd1, 32'd1, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if ({alu_op, a, b} !== 67'd0) begin errors++; $display("[TB] FAIL midrst_operands: got %0d %h %h expected 0 0 0", alu_op, a, b); end
        checks++; if ({rsp_valid, rsp_f, rsp_zf, rsp_of} !== 35'd0) begin errors++; $display("[TB] FAIL midrst_rsp: got %b %h %b %b expected all 0", rsp_valid, rsp_f, rsp_zf, rsp_of); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 1", req_ready); end
`ifdef ALU_DRIVER_STICKY_OF_EN
        checks++; if (sticky_of !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sticky: got %b expected 0", sticky_of); end
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_result[%0d]: got %b expected 0", i, rsp_valid); end
        end
        apply_stimulus(1'b1, 3'b100, 32'd2, 32'd2, 1'b1);
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        checks++; if ({rsp_valid, rsp_f} !== {1'b1, 32'd4}) begin errors++; $display("[TB] FAIL midrst_new_op: got %b %h expected 1 00000004", rsp_valid, rsp_f); end
        apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        $display("[TB] starting alu_driver bench, DEPTH=%0d", DEPTH);
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
